alu_issue: RTL and testbench
============================

ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 cmd_valid  input  1  upstream command present.
REQ-004 cmd_ready  output  1  block can accept a command this cycle.
REQ-005 cmd_a, cmd_b  input  4 each  command operands, unsigned.
REQ-006 cmd_sel  input  4  ALU opcode, 16 codes, 4'b0011 = divide.
REQ-007 alu_a, alu_b, alu_sel  output  4 each  operands and opcode driven to the downstream combinational ALU.
REQ-008 alu_y  input  8  combinational ALU result for alu_a/alu_b/alu_sel.
REQ-009 res_valid  output  1  result register holds an unconsumed result.
REQ-010 res_ready  input  1  downstream accepts the result.
REQ-011 res_data  output  8  captured result.
REQ-012 res_sel  output  4  opcode that produced res_data.
REQ-013 res_err  output  1  result is a divide-by-zero substitute.
REQ-014 fifo_count  output  3  command FIFO occupancy, 0..4.

Function
REQ-015 Command FIFO SHALL be 4 entries of {sel,a,b}, 12 bits each, first in first out.
REQ-016 cmd_ready SHALL equal (fifo_count < 4), decoded from registered count only, never from pop.
REQ-017 Push SHALL occur on edge where cmd_valid && cmd_ready; cmd_* ignored otherwise.
REQ-018 Issue FSM SHALL have states IDLE, EXEC, WAIT.
REQ-019 IDLE: if fifo_count != 0, pop head into issue register, go EXEC; else stay IDLE.
REQ-020 EXEC: exactly one cycle; alu_a/alu_b/alu_sel driven from issue register; at the edge ending EXEC, capture result into res_*, set res_valid, go WAIT.
REQ-021 WAIT: if res_ready, clear res_valid; then pop and go EXEC if fifo_count != 0, else go IDLE; if !res_ready, hold all res_* and stay WAIT.
REQ-022 alu_a/alu_b/alu_sel SHALL be registered outputs of the issue register; they hold their last value in IDLE and WAIT.
REQ-023 Captured result: if alu_sel == 4'b0011 and alu_b == 0, res_data = 8'hFF and res_err = 1; otherwise res_data = alu_y and res_err = 0.
REQ-024 res_sel SHALL be alu_sel at capture time.
REQ-025 Simultaneous push and pop SHALL leave fifo_count unchanged and preserve order; pushed entry never bypasses to the issue register in the same cycle.
REQ-026 Latency: command pushed at edge N to an empty, idle block SHALL produce res_valid = 1 after edge N+2; sustained throughput is one result per 2 cycles with res_ready held high.
REQ-027 Read and write pointers SHALL be 2-bit and wrap modulo 4.
REQ-028 res_* SHALL be stable while res_valid && !res_ready.

Reset
REQ-029 With rst high at an edge: FSM to IDLE, fifo_count = 0, pointers = 0, alu_a/alu_b/alu_sel = 0, res_valid = 0, res_data = 0, res_sel = 0, res_err = 0.
REQ-030 rst SHALL override any push, pop, or capture on the same edge; FIFO contents and an in-flight result are discarded.
REQ-031 cmd_ready SHALL be 1 in the first cycle after reset release.

Verification
REQ-032 Single add: push {sel=0000,a=3,b=5}, res_ready=1 -> res_valid rises two edges later, res_data=8'h08, res_sel=0000, res_err=0.
REQ-033 Divide by zero: push {0011,a=9,b=0} -> res_data=8'hFF, res_err=1; then push {0011,9,2} -> res_data=8'h04, res_err=0.
REQ-034 Full FIFO: res_ready=0, push 6 commands back-to-back -> first popped to EXEC, FIFO then fills to 4, cmd_ready=0, 6th held off; release res_ready -> 5 results in push order.
REQ-035 Backpressure: hold res_ready=0 for 10 cycles with result pending -> res_data/res_sel/res_err unchanged, FSM stays WAIT, and no further pop occurs.
REQ-036 Reset mid-operation: rst asserted while fifo_count=3 and in WAIT -> next cycle all outputs at REQ-029 values, cmd_ready=1, and no stale result appears afterward.
REQ-037 Pointer wrap: stream 12 commands (sel=1001 AND, a=i, b=4'hF) with res_ready=1 -> res_data = i for i=0..11, in order.

Source files
------------

// File: rtl/alu_issue.sv
// Purpose: queues up to 4 ALU commands, issues them one at a time to an external combinational ALU, and registers each result.
// Latency: a command pushed into an empty, idle block has res_valid set two edges later; one result per 2 cycles when sustained.
// Backpressure: cmd_ready drops when the FIFO holds 4; while res_valid && !res_ready the result holds and no further pop occurs.
module alu_issue (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_a,
  input  logic [3:0] cmd_b,
  input  logic [3:0] cmd_sel,
  output logic [3:0] alu_a,
  output logic [3:0] alu_b,
  output logic [3:0] alu_sel,
  input  logic [7:0] alu_y,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_data,
  output logic [3:0] res_sel,
  output logic       res_err,
  output logic [2:0] fifo_count
);

  localparam logic [3:0] SEL_DIV = 4'b0011;

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] a;
    logic [3:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, EXEC, WAIT} state_t;

  state_t     state, state_nxt;
  cmd_t       mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic       push, pop, capture;

  // Ready comes from the registered count only, so a pop in this cycle never opens a slot early.
  assign cmd_ready = (fifo_count < 3'd4);
  assign push      = cmd_valid && cmd_ready;

  // Issue FSM next-state: pop into the issue register, execute for one cycle, then hold the result until taken.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (fifo_count != 3'd0) begin
          pop       = 1'b1;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = WAIT;
      end
      WAIT: begin
        if (res_ready) begin
          if (fifo_count != 3'd0) begin
            pop       = 1'b1;
            state_nxt = EXEC;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FIFO storage; contents need no reset because the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{sel: cmd_sel, a: cmd_a, b: cmd_b};
  end

  // FIFO pointers and occupancy; 2-bit pointers wrap naturally modulo 4.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      fifo_count <= 3'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Issue register drives the ALU directly and holds its value outside of a pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_sel <= 4'd0;
      alu_a   <= 4'd0;
      alu_b   <= 4'd0;
    end else if (pop) begin
      alu_sel <= mem[rd_ptr].sel;
      alu_a   <= mem[rd_ptr].a;
      alu_b   <= mem[rd_ptr].b;
    end
  end

  // Result register: capture at the end of EXEC, substituting 8'hFF for divide-by-zero; release on res_ready.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid <= 1'b0;
      res_data  <= 8'd0;
      res_sel   <= 4'd0;
      res_err   <= 1'b0;
    end else if (capture) begin
      res_valid <= 1'b1;
      res_sel   <= alu_sel;
      if (alu_sel == SEL_DIV && alu_b == 4'd0) begin
        res_data <= 8'hFF;
        res_err  <= 1'b1;
      end else begin
        res_data <= alu_y;
        res_err  <= 1'b0;
      end
    end else if (state == WAIT && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Testbench for alu_issue: directed commands, expected results queued at acceptance and checked by a monitor.
// A small behavioural ALU drives alu_y from the DUT's alu_* outputs.
// Results are compared in order whenever res_valid && res_ready is seen.
module tb_alu_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_a, cmd_b, cmd_sel;
  logic [3:0] alu_a, alu_b, alu_sel;
  logic [7:0] alu_y;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic [3:0] res_sel;
  logic       res_err;
  logic [2:0] fifo_count;

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] sel;
    logic       err;
  } exp_t;

  exp_t sb [$];
  int   n_chk  = 0;
  int   n_fail = 0;

  alu_issue dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_sel    (cmd_sel),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_sel    (alu_sel),
    .alu_y      (alu_y),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_sel    (res_sel),
    .res_err    (res_err),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  // Environment ALU: add, subtract, divide (0 on b==0), AND, XOR otherwise.
  function automatic logic [7:0] alu_model(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b);
    case (s)
      4'h0:    return {4'd0, a} + {4'd0, b};
      4'h1:    return {4'd0, a} - {4'd0, b};
      4'h3:    return (b == 4'd0) ? 8'h00 : {4'd0, a / b};
      4'h9:    return {4'd0, a & b};
      default: return {4'd0, a ^ b};
    endcase
  endfunction

  assign alu_y = alu_model(alu_sel, alu_a, alu_b);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Present a command (called just after a rising edge) and queue its hand-computed result once accepted.
  task automatic send(input logic [3:0] s, input logic [3:0] a, input logic [3:0] b,
                      input logic [7:0] d, input logic e);
    exp_t x;
    int   w;
    cmd_sel   = s;
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    if (!cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: cmd_ready stuck at 0 for sel=%0h a=%0h b=%0h", s, a, b);
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk);
    x.data = d;
    x.sel  = s;
    x.err  = e;
    sb.push_back(x);
    #1 cmd_valid = 1'b0;
  endtask

  // Wait until every queued result has been consumed; ends just after a rising edge.
  task automatic drain();
    int w;
    w = 0;
    while (w < 300) begin
      @(negedge clk);
      if (sb.size() == 0 && !res_valid) break;
      w++;
    end
    if (w >= 300) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results still outstanding", sb.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state();
    chk("rst_cmd_ready",  32'(cmd_ready),  32'd1);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_res_valid",  32'(res_valid),  32'd0);
    chk("rst_res_data",   32'(res_data),   32'd0);
    chk("rst_res_sel",    32'(res_sel),    32'd0);
    chk("rst_res_err",    32'(res_err),    32'd0);
    chk("rst_alu_abs",    32'({alu_a, alu_b, alu_sel}), 32'd0);
  endtask

  // Monitor: each result consumed at the next edge is compared with the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && res_valid && res_ready) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_result: got data=%0h sel=%0h err=%0b required none", res_data, res_sel, res_err);
      end else begin
        e = sb.pop_front();
        chk("res_data", 32'(res_data), 32'(e.data));
        chk("res_sel",  32'(res_sel),  32'(e.sel));
        chk("res_err",  32'(res_err),  32'(e.err));
      end
    end
  end

  initial begin
    logic stale;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = 4'd0;
    cmd_b     = 4'd0;
    cmd_sel   = 4'd0;
    res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state();

    // Single add with exact latency: accepted at edge N, res_valid after N+2.
    @(posedge clk); #1;
    res_ready = 1'b1;
    send(4'h0, 4'd3, 4'd5, 8'h08, 1'b0);
    @(negedge clk);
    chk("lat_after_n",   32'(res_valid), 32'd0);
    @(negedge clk);
    chk("lat_after_n1",  32'(res_valid), 32'd0);
    chk("exec_alu_ab",   32'({alu_sel, alu_a, alu_b}), 32'h035);
    @(negedge clk);
    chk("lat_after_n2",  32'(res_valid), 32'd1);
    drain();

    // Divide by zero substitution, then a normal divide.
    send(4'h3, 4'd9, 4'd0, 8'hFF, 1'b1);
    send(4'h3, 4'd9, 4'd2, 8'h04, 1'b0);
    drain();

    // Full FIFO: first command goes to the result register, next four fill the FIFO.
    res_ready = 1'b0;
    send(4'h0, 4'd1, 4'd2, 8'h03, 1'b0);
    send(4'h1, 4'd7, 4'd2, 8'h05, 1'b0);
    send(4'h9, 4'hC, 4'hA, 8'h08, 1'b0);
    send(4'h3, 4'd8, 4'd3, 8'h02, 1'b0);
    send(4'h5, 4'd6, 4'd3, 8'h05, 1'b0);
    @(negedge clk);
    chk("full_count",     32'(fifo_count), 32'd4);
    chk("full_cmd_ready", 32'(cmd_ready),  32'd0);
    chk("full_res_valid", 32'(res_valid),  32'd1);

    // Sixth command offered while full; result held under backpressure for 10 cycles.
    @(posedge clk); #1;
    cmd_sel   = 4'h0;
    cmd_a     = 4'hF;
    cmd_b     = 4'hF;
    cmd_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_result", 32'({res_valid, res_data, res_sel, res_err}), 32'({1'b1, 8'h03, 4'h0, 1'b0}));
      chk("hold_count",  32'(fifo_count), 32'd4);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    res_ready = 1'b1;
    drain();

    // Reset while waiting with three commands queued.
    res_ready = 1'b0;
    send(4'h0, 4'd2, 4'd2, 8'h04, 1'b0);
    send(4'h0, 4'd1, 4'd1, 8'h02, 1'b0);
    send(4'h0, 4'd3, 4'd3, 8'h06, 1'b0);
    send(4'h0, 4'd4, 4'd4, 8'h08, 1'b0);
    @(negedge clk);
    chk("pre_rst_count", 32'(fifo_count), 32'd3);
    chk("pre_rst_valid", 32'(res_valid),  32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check_reset_state();
    @(posedge clk); #1;
    res_ready = 1'b1;
    stale = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (res_valid) stale = 1'b1;
    end
    chk("no_stale_result", 32'(stale), 32'd0);
    chk("post_rst_count",  32'(fifo_count), 32'd0);
    @(posedge clk); #1;

    // Pointer wrap: 12 AND commands with b=F return a.
    for (int i = 0; i < 12; i++) begin
      send(4'h9, i[3:0], 4'hF, 8'(i), 1'b0);
    end
    drain();

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
